// File: rtl/rcu_pkg.sv
// Shared RCU types: sequencer state encoding, PLL divider bundle and legality check.
package rcu_pkg;

  localparam int unsigned REFDIV_W  = 6;
  localparam int unsigned FBDIV_W   = 12;
  localparam int unsigned POSTDIV_W = 3;
  localparam int unsigned FBDIV_MIN = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SW_OUT,
    ST_PWRDN,
    ST_RELOCK,
    ST_SW_IN,
    ST_TIMEOUT
  } rcu_state_e;

  typedef struct packed {
    logic [REFDIV_W-1:0]  refdiv;
    logic [FBDIV_W-1:0]   fbdiv;
    logic [POSTDIV_W-1:0] postdiv1;
    logic [POSTDIV_W-1:0] postdiv2;
  } pll_cfg_t;

  function automatic logic cfg_legal(input pll_cfg_t c);
    return (c.refdiv != '0) &&
           (c.fbdiv >= FBDIV_W'(FBDIV_MIN)) &&
           (c.postdiv1 != '0) &&
           (c.postdiv2 != '0) &&
           (c.postdiv2 <= c.postdiv1);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for slow level signals crossing into clk_i.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rcu_pll_seq.sv
// PLL reconfiguration sequencer: park core clock on HF osc, power-cycle and
// reprogram the PLL, wait for stable lock, then hand the core clock back.
module rcu_pll_seq
  import rcu_pkg::*;
#(
  parameter int unsigned PD_CYCLES    = 16,
  parameter int unsigned SW_CYCLES    = 8,
  parameter int unsigned LOCK_STABLE  = 4,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned DEF_REFDIV   = 1,
  parameter int unsigned DEF_FBDIV    = 32,
  parameter int unsigned DEF_POSTDIV1 = 1,
  parameter int unsigned DEF_POSTDIV2 = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [REFDIV_W-1:0]  cfg_refdiv_i,
  input  logic [FBDIV_W-1:0]   cfg_fbdiv_i,
  input  logic [POSTDIV_W-1:0] cfg_postdiv1_i,
  input  logic [POSTDIV_W-1:0] cfg_postdiv2_i,
  input  logic                 pll_lock_i,
  output logic [REFDIV_W-1:0]  pll_refdiv_o,
  output logic [FBDIV_W-1:0]   pll_fbdiv_o,
  output logic [POSTDIV_W-1:0] pll_postdiv1_o,
  output logic [POSTDIV_W-1:0] pll_postdiv2_o,
  output logic                 pll_pd_o,
  output logic                 clk_sel_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int unsigned MAX_A = (PD_CYCLES > SW_CYCLES) ? PD_CYCLES : SW_CYCLES;
  localparam int unsigned MAX_B = (LOCK_STABLE > LOCK_TIMEOUT) ? LOCK_STABLE : LOCK_TIMEOUT;
  localparam int unsigned MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W = $clog2(MAX_P) + 1;
  localparam int unsigned STB_W = $clog2(LOCK_STABLE) + 1;

  localparam logic [CNT_W-1:0] SW_LOAD = CNT_W'(SW_CYCLES - 1);
  localparam logic [CNT_W-1:0] PD_LOAD = CNT_W'(PD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(LOCK_TIMEOUT - 1);

  localparam pll_cfg_t DEF_CFG = '{
    refdiv:   REFDIV_W'(DEF_REFDIV),
    fbdiv:    FBDIV_W'(DEF_FBDIV),
    postdiv1: POSTDIV_W'(DEF_POSTDIV1),
    postdiv2: POSTDIV_W'(DEF_POSTDIV2)
  };

  rcu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [STB_W-1:0] stable_q;
  logic [STB_W-1:0] stable_d;
  pll_cfg_t         hold_q;
  pll_cfg_t         div_q;
  pll_cfg_t         req_d;
  logic             pd_q;
  logic             sel_q;
  logic             done_q;
  logic             err_q;
  logic             lock_s;

  sync2 #(.WIDTH(1)) u_lock_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (pll_lock_i),
    .q_o     (lock_s)
  );

  always_comb begin
    req_d    = '{refdiv: cfg_refdiv_i, fbdiv: cfg_fbdiv_i,
                 postdiv1: cfg_postdiv1_i, postdiv2: cfg_postdiv2_i};
    stable_d = lock_s ? (stable_q + STB_W'(1)) : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      stable_q <= '0;
      hold_q   <= DEF_CFG;
      div_q    <= DEF_CFG;
      pd_q     <= 1'b0;
      sel_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cfg_valid_i) begin
            if (cfg_legal(req_d)) begin
              state_q <= ST_SW_OUT;
              cnt_q   <= SW_LOAD;
              sel_q   <= 1'b0;
              err_q   <= 1'b0;
              hold_q  <= req_d;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_SW_OUT: begin
          if (cnt_q == '0) begin
            state_q <= ST_PWRDN;
            cnt_q   <= PD_LOAD;
            pd_q    <= 1'b1;
            div_q   <= hold_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_PWRDN: begin
          if (cnt_q == '0) begin
            state_q  <= ST_RELOCK;
            cnt_q    <= TO_LOAD;
            stable_q <= '0;
            pd_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RELOCK: begin
          stable_q <= stable_d;
          // Lock check precedes the timeout so a simultaneous hit still succeeds.
          if (stable_d == STB_W'(LOCK_STABLE)) begin
            state_q <= ST_SW_IN;
            cnt_q   <= SW_LOAD;
            sel_q   <= 1'b1;
          end else if (cnt_q == '0) begin
            state_q <= ST_TIMEOUT;
            pd_q    <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_SW_IN: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_TIMEOUT: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  assign cfg_ready_o    = (state_q == ST_IDLE);
  assign busy_o         = (state_q != ST_IDLE);
  assign pll_refdiv_o   = div_q.refdiv;
  assign pll_fbdiv_o    = div_q.fbdiv;
  assign pll_postdiv1_o = div_q.postdiv1;
  assign pll_postdiv2_o = div_q.postdiv2;
  assign pll_pd_o       = pd_q;
  assign clk_sel_o      = sel_q;
  assign done_o         = done_q;
  assign err_o          = err_q;

endmodule
